// File: rtl/refill_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : refill_pkg                                                        |
// | Brief  : Shared state encoding and sizing helper for the refill engine.    |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
package refill_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } refill_state_t;

  function automatic int beats(input int block_size);
    return 1 << block_size;
  endfunction

endpackage
`default_nettype wire

// File: rtl/refill_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : refill_controller_if                                              |
// | Brief  : Cache-side, memory-side and line-fill signals of the refill engine.|
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
interface refill_controller_if
  import refill_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 30,
  parameter int BLOCK_SIZE    = 3
);
  localparam int BEATS = beats(BLOCK_SIZE);

  logic                                miss;
  logic [ADDRESS_WIDTH-1:0]            miss_address;
  logic                                stall;
  logic                                mem_req;
  logic [ADDRESS_WIDTH-1:0]            mem_address;
  logic                                mem_ack;
  logic [DATA_WIDTH-1:0]               mem_rdata;
  logic                                line_valid;
  logic [ADDRESS_WIDTH-BLOCK_SIZE-1:0] line_address;
  logic [DATA_WIDTH*BEATS-1:0]         line_data;
  logic                                crit_valid;

  // master: the cache/memory environment; slave: the refill controller
  modport master (
    output miss, miss_address, mem_ack, mem_rdata,
    input  stall, mem_req, mem_address, line_valid, line_address, line_data, crit_valid
  );

  modport slave (
    input  miss, miss_address, mem_ack, mem_rdata,
    output stall, mem_req, mem_address, line_valid, line_address, line_data, crit_valid
  );

endinterface
`default_nettype wire

// File: rtl/refill_line_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : refill_line_buffer                                                |
// | Brief  : Word-addressable line assembly buffer with synchronous clear.     |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module refill_line_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int BEATS      = 8,
  parameter int IDX_WIDTH  = 3
) (
  input  logic                        clk,
  input  logic                        clr_i,
  input  logic                        we_i,
  input  logic [IDX_WIDTH-1:0]        idx_i,
  input  logic [DATA_WIDTH-1:0]       wdata_i,
  output logic [DATA_WIDTH*BEATS-1:0] line_data_o
);

  logic [DATA_WIDTH-1:0] words_q [BEATS];

  always_ff @(posedge clk) begin
    if (clr_i) begin
      for (int i = 0; i < BEATS; i++) begin
        words_q[i] <= '0;
      end
    end else if (we_i) begin
      words_q[idx_i] <= wdata_i;
    end
  end

  for (genvar g = 0; g < BEATS; g++) begin : g_flat
    assign line_data_o[g*DATA_WIDTH +: DATA_WIDTH] = words_q[g];
  end

endmodule
`default_nettype wire

// File: rtl/refill_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : refill_controller                                                 |
// | Brief  : Multi-beat cache block refill engine; optional critical-word-first|
// |          ordering enabled by macro REFILL_CRITICAL_WORD_FIRST_EN.          |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module refill_controller
  import refill_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 30,
  parameter int BLOCK_SIZE    = 3
) (
  input logic               clk,
  input logic               rst,
  refill_controller_if.slave bus
);

  localparam int BEATS  = beats(BLOCK_SIZE);
  localparam int BASE_W = ADDRESS_WIDTH - BLOCK_SIZE;

  refill_state_t         state_q;
  logic [BLOCK_SIZE-1:0] beat_q;
  logic [BLOCK_SIZE-1:0] last_q;
  logic [BASE_W-1:0]     base_q;
  logic [BASE_W-1:0]     line_address_q;
  logic                  mem_req_q;
  logic                  line_valid_q;
  logic [BLOCK_SIZE-1:0] w_start;
  logic                  w_beat_we;

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
  logic first_q;
  assign w_start        = bus.miss_address[BLOCK_SIZE-1:0];
  assign bus.crit_valid = (state_q == FETCH) & bus.mem_ack & first_q;
`else
  logic unused_offset;
  assign w_start        = '0;
  assign unused_offset  = ^bus.miss_address[BLOCK_SIZE-1:0];
  assign bus.crit_valid = 1'b0;
`endif

  assign w_beat_we        = (state_q == FETCH) & bus.mem_ack;
  assign bus.stall        = bus.miss | (state_q != IDLE);
  assign bus.mem_req      = mem_req_q;
  assign bus.mem_address  = {base_q, beat_q};
  assign bus.line_valid   = line_valid_q;
  assign bus.line_address = line_address_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      beat_q         <= '0;
      last_q         <= '0;
      base_q         <= '0;
      line_address_q <= '0;
      mem_req_q      <= 1'b0;
      line_valid_q   <= 1'b0;
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
      first_q        <= 1'b0;
`endif
    end else begin
      line_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.miss) begin
            base_q    <= bus.miss_address[ADDRESS_WIDTH-1:BLOCK_SIZE];
            beat_q    <= w_start;
            // Final beat is the one just before the start offset, wrapping
            last_q    <= w_start - BLOCK_SIZE'(1);
            mem_req_q <= 1'b1;
            state_q   <= FETCH;
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
            first_q   <= 1'b1;
`endif
          end
        end
        FETCH: begin
          if (bus.mem_ack) begin
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
            first_q <= 1'b0;
`endif
            if (beat_q == last_q) begin
              mem_req_q      <= 1'b0;
              line_valid_q   <= 1'b1;
              line_address_q <= base_q;
              state_q        <= DONE;
            end else begin
              beat_q <= beat_q + BLOCK_SIZE'(1);
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  refill_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .BEATS      (BEATS),
    .IDX_WIDTH  (BLOCK_SIZE)
  ) u_line_buffer (
    .clk         (clk),
    .clr_i       (rst),
    .we_i        (w_beat_we),
    .idx_i       (beat_q),
    .wdata_i     (bus.mem_rdata),
    .line_data_o (bus.line_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_refill_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_refill_controller                                              |
// | Brief  : Directed vector and sequence bench for refill_controller.         |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_refill_controller;

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  refill_controller_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(30), .BLOCK_SIZE(3)) bus ();

  refill_controller #(.DATA_WIDTH(32), .ADDRESS_WIDTH(30), .BLOCK_SIZE(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        miss;
    logic [29:0] maddr;
    logic        ack;
    logic [31:0] rdata;
    logic        e_stall;
    logic        e_req;
    logic        chk_addr;
    logic [29:0] e_addr;
    logic        e_lv;
    logic        e_crit;
    logic        chk_line;
  } vec_t;

  vec_t         tbl [11];
  logic [255:0] exp_line;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drives one refill from a miss at addr; ack every 'period' cycles, data = 0xA0 + word index
  task automatic refill(input logic [29:0] addr, input int period, input bit hold,
                        output int stall_cycles);
    int          cyc;
    int          acks;
    bit          got_lv;
    logic [2:0]  start;
    logic [29:0] prev_addr;
    bit          prev_req;
    cyc = 0; acks = 0; got_lv = 0; prev_req = 0; prev_addr = '0;
    start = CWF ? addr[2:0] : 3'd0;
    @(negedge clk);
    bus.miss = 1'b1; bus.miss_address = addr; bus.mem_ack = 1'b0;
    #1;
    check("miss_stall", bus.stall, 1'b1);
    stall_cycles = 1;
    while (!got_lv && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (!hold) bus.miss = 1'b0;
      if (hold && acks == 2) bus.miss_address = 30'h200;
      bus.mem_ack   = ((cyc % period) == 0);
      bus.mem_rdata = 32'hA0 + 32'(bus.mem_address[2:0]);
      #1;
      if (bus.stall) stall_cycles++;
      if (prev_req && bus.mem_req) check("addr_hold", bus.mem_address, prev_addr);
      prev_req = bus.mem_req && !bus.mem_ack;
      prev_addr = bus.mem_address;
      if (bus.mem_req && bus.mem_ack) begin
        check("beat_addr", bus.mem_address, {addr[29:3], 3'(start + 3'(acks))});
        check("crit_on_ack", bus.crit_valid, CWF && (acks == 0));
        acks++;
      end else if (bus.crit_valid !== 1'b0) begin
        check("crit_idle", bus.crit_valid, 1'b0);
      end
      if (bus.line_valid) begin
        got_lv = 1;
        check("beats_seen", acks, 8);
        check("line_addr", bus.line_address, addr[29:3]);
        check("line_data", bus.line_data, exp_line);
        check("done_req", bus.mem_req, 1'b0);
      end
    end
    check("lv_timeout", got_lv, 1'b1);
  endtask

  initial begin
    int st;
    int lv_cnt;
    bit seen;
    n_checks = 0;
    n_fail = 0;
    for (int i = 0; i < 8; i++) exp_line[i*32 +: 32] = 32'hA0 + 32'(i);

    // Table: miss at 0x123, ack every cycle; ack in the IDLE cycle must be ignored
    for (int k = 0; k < 11; k++) begin
      tbl[k] = '{rst: 1'b0, miss: (k == 0), maddr: 30'h123, ack: (k <= 9),
                 rdata: 32'hEE, e_stall: (k <= 9), e_req: (k >= 1 && k <= 8),
                 chk_addr: (k >= 1 && k <= 8), e_addr: 30'h0, e_lv: (k == 9),
                 e_crit: (CWF && k == 1), chk_line: (k >= 9)};
      if (k >= 1 && k <= 8) begin
        tbl[k].e_addr = 30'h120 + 30'(((CWF ? 3 : 0) + k - 1) % 8);
        tbl[k].rdata  = 32'hA0 + 32'(((CWF ? 3 : 0) + k - 1) % 8);
      end
    end

    rst = 1'b1;
    bus.miss = 1'b0; bus.miss_address = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_stall", bus.stall, 1'b0);
    check("rst_req", bus.mem_req, 1'b0);
    check("rst_lv", bus.line_valid, 1'b0);
    check("rst_line", bus.line_data, '0);
    check("rst_laddr", bus.line_address, '0);
    check("rst_crit", bus.crit_valid, 1'b0);

    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      rst = tbl[k].rst;
      bus.miss = tbl[k].miss; bus.miss_address = tbl[k].maddr;
      bus.mem_ack = tbl[k].ack; bus.mem_rdata = tbl[k].rdata;
      #1;
      check($sformatf("v%0d_stall", k), bus.stall, tbl[k].e_stall);
      check($sformatf("v%0d_req", k), bus.mem_req, tbl[k].e_req);
      check($sformatf("v%0d_lv", k), bus.line_valid, tbl[k].e_lv);
      check($sformatf("v%0d_crit", k), bus.crit_valid, tbl[k].e_crit);
      if (tbl[k].chk_addr) check($sformatf("v%0d_addr", k), bus.mem_address, tbl[k].e_addr);
      if (tbl[k].chk_line) begin
        check($sformatf("v%0d_line", k), bus.line_data, exp_line);
        check($sformatf("v%0d_laddr", k), bus.line_address, 30'h24);
      end
    end

    // Wait states: ack every 3rd cycle adds 16 stall cycles
    refill(30'h123, 3, 1'b0, st);
    check("ws_stall_cycles", st, 26);
    @(negedge clk); bus.mem_ack = 1'b0; #1;
    check("ws_release", bus.stall, 1'b0);

    // Reset in the middle of a refill discards the partial line
    @(negedge clk);
    bus.miss = 1'b1; bus.miss_address = 30'h123; bus.mem_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.miss = 1'b0; bus.mem_ack = 1'b1;
      bus.mem_rdata = 32'hA0 + 32'(bus.mem_address[2:0]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.mem_ack = 1'b1;
    #1;
    check("mrst_stall", bus.stall, 1'b0);
    check("mrst_req", bus.mem_req, 1'b0);
    check("mrst_line", bus.line_data, '0);
    check("mrst_lv", bus.line_valid, 1'b0);
    lv_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      if (bus.line_valid || bus.mem_req) lv_cnt++;
    end
    bus.mem_ack = 1'b0;
    check("mrst_quiet", lv_cnt, 0);
    refill(30'h123, 1, 1'b0, st);
    check("post_rst_stall_cycles", st, 10);

    // miss_address changes mid-refill and miss stays high: back-to-back refill of new block
    refill(30'h123, 1, 1'b1, st);
    @(negedge clk); bus.mem_ack = 1'b0; #1;
    check("b2b_idle_stall", bus.stall, 1'b1);
    check("b2b_idle_req", bus.mem_req, 1'b0);
    @(negedge clk); bus.miss = 1'b0; #1;
    check("b2b_req", bus.mem_req, 1'b1);
    check("b2b_addr", bus.mem_address, 30'h200);
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      bus.mem_ack = 1'b1;
      bus.mem_rdata = 32'hA0 + 32'(bus.mem_address[2:0]);
      #1;
      if (bus.line_valid) seen = 1;
    end
    check("b2b_lv", seen, 1'b1);
    check("b2b_laddr", bus.line_address, 30'h40);
    check("b2b_line", bus.line_data, exp_line);
    @(negedge clk); bus.mem_ack = 1'b0; #1;
    check("b2b_release", bus.stall, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
